// File: rtl/half_pkg.sv
// Shared constants and FSM state type for the integer-to-binary16 converter.
package half_pkg;
  localparam int HALF_BIAS  = 15;
  localparam int HALF_EXP_W = 5;
  localparam int HALF_MAN_W = 10;
  localparam logic [15:0] HALF_POS_INF = 16'h7C00;

  // Exponent for a magnitude whose leading one sits in bit 15.
  localparam logic [HALF_EXP_W-1:0] EXP_INIT = HALF_EXP_W'(HALF_BIAS + 15);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;
endpackage

// File: rtl/leading_zero_count.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module leading_zero_count #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = CNT_W'(WIDTH);
    // Scanning upward lets the highest set bit have the final say.
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/half_from_int.sv
// 16-bit integer to IEEE-754 binary16 converter, round-to-nearest-even.
// HALF_FROM_INT_FAST_NORM_EN selects a single-cycle normalise via leading_zero_count.
module half_from_int
  import half_pkg::*;
#(
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c
);

  state_t                  state, state_nxt;
  logic                    sign_r;
  logic [15:0]             mag;
  logic [HALF_EXP_W-1:0]   expo;
  logic [15:0]             c_r;

  logic signed [15:0]      a_s;
  logic                    sign_in;
  logic [15:0]             mag_in;

  assign a_s     = a;
  assign sign_in = (SIGNED != 0) && a_s[15];
  assign mag_in  = sign_in ? 16'(-a_s) : a;

`ifdef HALF_FROM_INT_FAST_NORM_EN
  logic [4:0] lz;

  leading_zero_count #(
    .WIDTH (16)
  ) u_lzc (
    .value (mag),
    .count (lz)
  );
`endif

  // Returns {exponent, mantissa}; overflow to exponent 31 saturates to infinity.
  function automatic logic [14:0] round_rne(input logic [15:0] m,
                                            input logic [HALF_EXP_W-1:0] e);
    logic                  inc;
    logic [HALF_MAN_W:0]   man_inc;
    logic [HALF_EXP_W-1:0] e_inc;
    inc     = m[4] & ((|m[3:0]) | m[5]);
    man_inc = {1'b0, m[14:5]} + (HALF_MAN_W + 1)'(inc);
    e_inc   = e + HALF_EXP_W'(man_inc[HALF_MAN_W]);
    if (e_inc == HALF_EXP_W'(31)) return HALF_POS_INF[14:0];
    return {e_inc, man_inc[HALF_MAN_W-1:0]};
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = (mag_in == 16'h0000) ? DONE : NORM;
`ifdef HALF_FROM_INT_FAST_NORM_EN
      NORM:  state_nxt = ROUND;
`else
      NORM:  if (mag[15]) state_nxt = ROUND;
`endif
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: capture in IDLE, normalise in NORM, round into c in ROUND.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sign_r <= 1'b0;
      mag    <= 16'h0000;
      expo   <= '0;
      c_r    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= sign_in;
            mag    <= mag_in;
            expo   <= EXP_INIT;
            if (mag_in == 16'h0000) c_r <= 16'h0000;
          end
        end
        NORM: begin
`ifdef HALF_FROM_INT_FAST_NORM_EN
          mag  <= mag << lz;
          expo <= expo - lz;
`else
          if (!mag[15]) begin
            mag  <= mag << 1;
            expo <= expo - HALF_EXP_W'(1);
          end
`endif
        end
        ROUND: c_r <= {sign_r, round_rne(mag, expo)};
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign c         = c_r;

endmodule

// File: tb/tb_half_from_int.sv
// Directed and streaming random checks of half_from_int, signed and unsigned builds.
module tb_half_from_int;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        out_ready;
  logic        sel;
  logic [15:0] a;

  logic        in_valid_s, in_ready_s, out_valid_s;
  logic        in_valid_u, in_ready_u, out_valid_u;
  logic [15:0] c_s, c_u;
  logic        in_ready_o, out_valid_o;
  logic [15:0] c_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign in_valid_s  = in_valid & ~sel;
  assign in_valid_u  = in_valid & sel;
  assign in_ready_o  = sel ? in_ready_u  : in_ready_s;
  assign out_valid_o = sel ? out_valid_u : out_valid_s;
  assign c_o         = sel ? c_u         : c_s;

  half_from_int #(.SIGNED(1)) dut_s (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .a         (a),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .c         (c_s)
  );

  half_from_int #(.SIGNED(0)) dut_u (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid_u),
    .in_ready  (in_ready_u),
    .a         (a),
    .out_valid (out_valid_u),
    .out_ready (out_ready),
    .c         (c_u)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: locate the MSB, then round the discarded tail by value.
  function automatic logic [15:0] ref_half(input logic [15:0] v, input logic signed_mode);
    logic        s;
    int unsigned m, q, rem, half;
    int          p, e, sh;
    s = signed_mode && v[15];
    m = s ? (32'd65536 - 32'(v)) : 32'(v);
    if (m == 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 17; i++) if (m[i]) p = i;
    e = 15 + p;
    if (p <= 10) begin
      q = m << (10 - p);
    end else begin
      sh   = p - 10;
      q    = m >> sh;
      rem  = m & ((32'd1 << sh) - 1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == 2048) begin
        q = 1024;
        e++;
      end
    end
    if (e >= 31) return {s, 15'h7C00};
    return {s, e[4:0], q[9:0]};
  endfunction

  task automatic convert(input logic [15:0] val, output logic [15:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_o) check("accept_timeout", 32'(in_ready_o), 32'd1);
    a        = val;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid_o && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid_o) check("result_timeout", 32'(out_valid_o), 32'd1);
    res = c_o;
  endtask

  task automatic conv_check(input string tag, input logic [15:0] val, input logic [15:0] exp);
    logic [15:0] r;
    int          l;
    convert(val, r, l);
    check(tag, 32'(r), 32'(exp));
  endtask

  task automatic stream(input int n);
    logic [15:0] q[$];
    logic [15:0] v;
    int sent, got, cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    out_ready = 1'b1;
    while (got < n && cyc < n * 40) begin
      @(negedge clk);
      cyc++;
      if (in_ready_o && sent < n) begin
        if ($urandom_range(0, 7) == 0) v = 16'($urandom_range(0, 40));
        else                           v = 16'($urandom);
        a        = v;
        in_valid = 1'b1;
        q.push_back(ref_half(v, sel ? 1'b0 : 1'b1));
        sent++;
      end else begin
        in_valid = (sent < n);
      end
      @(posedge clk);
      #1;
      if (out_valid_o) begin
        if (q.size() == 0) check("rand_unexpected", 32'(out_valid_o), 32'd0);
        else               check("rand_conv", 32'(c_o), 32'(q.pop_front()));
        got++;
      end
    end
    in_valid = 1'b0;
    check("stream_count", 32'(got), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r, hold;
    int          l, lat_one, lat_l1;
`ifdef HALF_FROM_INT_FAST_NORM_EN
    lat_one = 2;
    lat_l1  = 2;
`else
    lat_one = 17;
    lat_l1  = 3;
`endif
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sel       = 1'b0;
    a         = 16'h0000;
    #1;
    check("reset_in_ready",  32'(in_ready_o),  32'd1);
    check("reset_out_valid", 32'(out_valid_o), 32'd0);
    check("reset_c",         32'(c_o),         32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    convert(16'd1, r, l);
    check("one_c", 32'(r), 32'h3C00);
    check("one_lat", 32'(l), 32'(lat_one));
    conv_check("neg_two", 16'hFFFE, 16'hC000);
    conv_check("two", 16'd2, 16'h4000);
    convert(16'd0, r, l);
    check("zero_c", 32'(r), 32'h0000);
    check("zero_lat", 32'(l), 32'd0);
    convert(16'd32767, r, l);
    check("max_pos_c", 32'(r), 32'h7800);
    check("max_pos_lat", 32'(l), 32'(lat_l1));
    convert(16'h8000, r, l);
    check("min_neg_c", 32'(r), 32'hF800);
    check("min_neg_lat", 32'(l), 32'd2);
    conv_check("tie_2049", 16'd2049, 16'h6800);
    conv_check("tie_2051", 16'd2051, 16'h6802);
    conv_check("tie_2053", 16'd2053, 16'h6802);
    conv_check("exact_2050", 16'd2050, 16'h6801);

    sel = 1'b1;
    conv_check("u_65535", 16'd65535, 16'h7C00);
    conv_check("u_2048", 16'd2048, 16'h6800);
    conv_check("u_65504", 16'd65504, 16'h7BFF);
    conv_check("u_32768", 16'h8000, 16'h7800);
    conv_check("u_65520", 16'd65520, 16'h7C00);
    sel = 1'b0;

    out_ready = 1'b0;
    convert(16'd3, hold, l);
    check("bp_c", 32'(hold), 32'h4200);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_c_stable",   32'(c_o),         32'(hold));
      check("bp_out_valid",  32'(out_valid_o), 32'd1);
      check("bp_in_ready",   32'(in_ready_o),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    check("bp_release_in_ready", 32'(in_ready_o), 32'd0);
    @(posedge clk);
    #1;
    check("bp_after_in_ready",  32'(in_ready_o),  32'd1);
    check("bp_after_out_valid", 32'(out_valid_o), 32'd0);

    out_ready = 1'b0;
    convert(16'd5, r, l);
    check("done_hold_c", 32'(r), 32'h4500);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_done_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_done_c",         32'(c_o),         32'h0);
    check("rst_done_in_ready",  32'(in_ready_o),  32'd1);
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;

    @(negedge clk);
    a        = 16'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("rst_norm_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_norm_c",         32'(c_o),         32'h0);
    check("rst_norm_in_ready",  32'(in_ready_o),  32'd1);
    @(negedge clk);
    rstn = 1'b1;
    conv_check("after_rst_three", 16'd3, 16'h4200);

    sel = 1'b0;
    stream(1500);
    sel = 1'b1;
    stream(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
